aes_cbc_decipher_ctrl: RTL
==========================

# aes_cbc_decipher_ctrl

CBC-mode chaining controller wrapped around the AES decipher round block. Accepts ciphertext blocks over a valid/ready stream, launches one decipher operation per block with `core_next`, XORs the core result with the chaining value (IV or previous ciphertext), and presents plaintext on a valid/ready output stream. Key expansion and `keylen` selection are outside this block; they are connected directly to the decipher core.

## Interface
Parameters: none.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `iv_load`  in  1  load `iv` into the chaining register; honoured only in IDLE.
- `iv`  in  128  initialisation vector.
- `in_valid`  in  1  ciphertext block available.
- `in_ready`  out  1  high when in IDLE and `iv_load`=0 (combinational).
- `in_block`  in  128  ciphertext block.
- `out_valid`  out  1  plaintext block available.
- `out_ready`  in  1  consumer accepts plaintext.
- `out_block`  out  128  plaintext block (registered).
- `core_next`  out  1  one-cycle start pulse to the decipher core.
- `core_block`  out  128  ciphertext to the core (registered, stable for the whole operation).
- `core_result`  in  128  core `new_block`.
- `core_ready`  in  1  core `ready`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Registers: `iv_reg`, `ct_reg` (drives `core_block`), `pt_reg` (drives `out_block`), and a 2-bit FSM.
- FSM states: IDLE, START, WAIT, OUT.
  - IDLE: if `iv_load`=1, then `iv_reg`<=`iv` and `in_ready`=0. Otherwise, on `in_valid`&`in_ready`: `ct_reg`<=`in_block`, go to START.
  - START: `core_next`=1 for exactly this cycle; go to WAIT.
  - WAIT: the core clears `ready` on the edge that samples `next`, so `core_ready` is low on entry. On the first cycle with `core_ready`=1: `pt_reg`<=`core_result ^ iv_reg`, `iv_reg`<=`ct_reg`, go to OUT.
  - OUT: `out_valid`=1. On `out_ready`=1, go to IDLE. `out_block` holds its value while stalled.
- `iv_load` in START, WAIT or OUT is ignored; the chaining value is not corrupted.
- `iv_load` and `in_valid` asserted together in IDLE: the IV load wins and the block is not accepted that cycle.
- Chaining persists across blocks until the next `iv_load`. The first block after reset chains with IV = 0.
- All arithmetic is 128-bit XOR. There are no counters to wrap.

## Timing
- Reset values: FSM=IDLE; `iv_reg`, `ct_reg`, `pt_reg` = 0; `out_valid`=0; `core_next`=0; `core_block`=0; `out_block`=0; `busy`=0; `in_ready`=1 when `iv_load`=0.
- Reset asserted mid-operation aborts the block and returns to IDLE. The decipher core is reset by the same `reset_n`.
- Input accepted at edge N:
  - `core_next` is high during cycle N+1.
  - The core runs for 51 cycles (128-bit key) or 71 cycles (256-bit key).
  - `out_valid` rises on the edge after the first `core_ready`=1 seen in WAIT.
- Throughput: one block per (core latency + 3 + output stall) cycles. No overlap between blocks.
- `out_valid` and `out_block` are registered. `in_ready` and `core_next` are decoded from FSM state (`in_ready` also gated by `iv_load`).

## Configuration
- Macro `AES_CBC_ECB_MODE_EN`.
- Defined:
  - Adds input port `ecb_mode` (1 bit), sampled into `mode_reg` at the input handshake.
  - When `mode_reg`=1: `pt_reg`<=`core_result` (no XOR) and `iv_reg` is not updated.
  - `mode_reg` resets to 0.
- Not defined: no `ecb_mode` port; CBC always.

## Test plan
- **Reset:** assert `reset_n`=0 in WAIT. Then: `out_valid`=0, `busy`=0, `in_ready`=1, `out_block`=0. Next block chains with IV = 0.
- **SP800-38A F.2.2, AES-128:** key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f.
  - ct 7649abac8119b246cee98e9b12e9197d -> pt 6bc1bee22e409f96e93d7e117393172a.
  - Then ct 5086cb9b507219ee95db113a917678b2 -> pt ae2d8a571e03ac9c9eb76fac45af8e51.
- **Stub core (identity, ready after 5 cycles):** IV=0xFF..FF, `in_block`=0x0. `core_next` is a single-cycle pulse at N+1, and `out_block`=0xFF..FF.
- **Output stall:** hold `out_ready`=0 for 20 cycles. `out_valid` and `out_block` stay stable, `in_ready`=0, and no second `core_next` is issued.
- **iv_load conflicts:**
  - `iv_load` with `in_valid` in IDLE: no accept that cycle, `iv_reg` updated.
  - `iv_load` pulsed in WAIT: ignored, and output is unchanged versus the reference run.
- **`AES_CBC_ECB_MODE_EN` defined, `ecb_mode`=1, stub identity core:** `out_block` = `in_block`, and the next CBC block still chains with the prior IV.

Source files
------------

// File: rtl/aes_cbc_decipher_ctrl.sv
// CBC chaining controller around the AES decipher core: one core operation per block, plaintext = core result ^ chaining value.
// Optional AES_CBC_ECB_MODE_EN adds a per-block ecb_mode input that bypasses the chaining XOR.
module aes_cbc_decipher_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         core_next,
  output logic [127:0] core_block,
  input  logic [127:0] core_result,
  input  logic         core_ready,
`ifdef AES_CBC_ECB_MODE_EN
  input  logic         ecb_mode,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t       state, state_next;
  logic [127:0] iv_reg, ct_reg, pt_reg;
  logic         out_valid_reg;
  logic         accept, core_done, out_done, chain_en;

`ifdef AES_CBC_ECB_MODE_EN
  logic mode_reg;
  assign chain_en = ~mode_reg;
`else
  assign chain_en = 1'b1;
`endif

  assign accept     = in_valid & in_ready;
  assign core_done  = (state == S_WAIT) & core_ready;
  assign out_done   = (state == S_OUT) & out_ready;
  assign core_block = ct_reg;
  assign out_block  = pt_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    core_next  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = ~iv_load;
        if (in_valid && !iv_load) state_next = S_START;
      end
      S_START: begin
        core_next  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT:  if (core_ready) state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      iv_reg        <= '0;
      ct_reg        <= '0;
      pt_reg        <= '0;
      out_valid_reg <= 1'b0;
`ifdef AES_CBC_ECB_MODE_EN
      mode_reg      <= 1'b0;
`endif
    end else begin
      state <= state_next;
      // iv_load outside IDLE is dropped so an in-flight chain is never corrupted
      if (state == S_IDLE && iv_load) iv_reg <= iv;
      if (accept) begin
        ct_reg <= in_block;
`ifdef AES_CBC_ECB_MODE_EN
        mode_reg <= ecb_mode;
`endif
      end
      if (core_done) begin
        pt_reg        <= chain_en ? (core_result ^ iv_reg) : core_result;
        out_valid_reg <= 1'b1;
        if (chain_en) iv_reg <= ct_reg;
      end else if (out_done) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule
